// File: rtl/claa_mp_seq_if.sv
// Handshake and data bundle for the multi-precision add/subtract sequencer.
// The producer/consumer side uses the master modport; the sequencer uses slave.
interface claa_mp_seq_if #(
    parameter int WORD_WIDTH = 8,
    parameter int CHUNKS     = 4
);
    localparam int N = WORD_WIDTH * CHUNKS;

    // valid/ready: a transfer happens on a rising clock edge where both are
    // high; valid stays asserted with stable payload until that edge.
    logic         valid_i;
    logic         ready_o;
    logic         sub_i;
    logic         c_i;
    logic [N-1:0] a_i;
    logic [N-1:0] b_i;
    logic         valid_o;
    logic         ready_i;
    logic [N-1:0] r_o;
    logic         c_o;
    logic         v_o;
    logic         z_o;

    modport master (
        output valid_i, sub_i, c_i, a_i, b_i, ready_i,
        input  ready_o, valid_o, r_o, c_o, v_o, z_o
    );

    modport slave (
        input  valid_i, sub_i, c_i, a_i, b_i, ready_i,
        output ready_o, valid_o, r_o, c_o, v_o, z_o
    );
endinterface

// File: rtl/claa_mp_seq.sv
// Wide add/subtract built from one WORD_WIDTH carry look-ahead slice reused
// over CHUNKS cycles, least-significant chunk first, carry kept in a register.
module claa_mp_seq #(
    parameter int WORD_WIDTH = 8,
    parameter int CHUNKS     = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    claa_mp_seq_if.slave       bus,
    output logic [1:0]         dbg_state_o
);
    localparam int N    = WORD_WIDTH * CHUNKS;
    localparam int IDXW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [IDXW-1:0] r_idx;
    logic            r_carry;
    logic            r_sub;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [N-1:0]    r_res;
    logic            r_c;
    logic            r_v;
    logic            r_z;

    logic [WORD_WIDTH-1:0] w_a_chunk;
    logic [WORD_WIDTH-1:0] w_b_chunk;
    logic [WORD_WIDTH-1:0] w_g;
    logic [WORD_WIDTH-1:0] w_p;
    logic [WORD_WIDTH:0]   w_c;
    logic [WORD_WIDTH-1:0] w_sum;
    logic                  w_term;
    logic                  w_prod;
    logic [N-1:0]          w_res_next;
    logic                  w_last;

    assign w_last = (r_idx == IDXW'(CHUNKS - 1));

    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int k = 0; k < CHUNKS; k++) begin
            if (r_idx == IDXW'(k)) begin
                w_a_chunk = r_a[k*WORD_WIDTH +: WORD_WIDTH];
                w_b_chunk = r_b[k*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    // Each carry is a flat sum of generate terms gated by propagate products,
    // so no carry depends on a lower carry of the same slice.
    always_comb begin
        w_g    = w_a_chunk & w_b_chunk;
        w_p    = w_a_chunk ^ w_b_chunk;
        w_c    = '0;
        w_term = 1'b0;
        w_prod = 1'b0;
        w_c[0] = r_carry;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            w_term = w_g[i];
            w_prod = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_term = w_term | (w_prod & w_g[j]);
                w_prod = w_prod & w_p[j];
            end
            w_c[i+1] = w_term | (w_prod & r_carry);
        end
        w_sum = w_p ^ w_c[WORD_WIDTH-1:0];
    end

    always_comb begin
        w_res_next = r_res;
        for (int k = 0; k < CHUNKS; k++) begin
            if (r_idx == IDXW'(k)) begin
                w_res_next[k*WORD_WIDTH +: WORD_WIDTH] = w_sum;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
            r_z     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.valid_i) begin
                        r_a     <= bus.a_i;
                        r_b     <= bus.sub_i ? ~bus.b_i : bus.b_i;
                        r_carry <= bus.sub_i ? ~bus.c_i : bus.c_i;
                        r_sub   <= bus.sub_i;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_res   <= w_res_next;
                    r_carry <= w_c[WORD_WIDTH];
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_c     <= r_sub ? ~w_c[WORD_WIDTH] : w_c[WORD_WIDTH];
                        r_v     <= (r_a[N-1] == r_b[N-1]) & (w_res_next[N-1] != r_a[N-1]);
                        r_z     <= (w_res_next == '0);
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready_o  = (r_state == S_IDLE);
    assign bus.valid_o  = (r_state == S_DONE);
    assign bus.r_o      = r_res;
    assign bus.c_o      = r_c;
    assign bus.v_o      = r_v;
    assign bus.z_o      = r_z;
    assign dbg_state_o  = r_state;
endmodule

// File: tb/tb_claa_mp_seq.sv
// Bench for claa_mp_seq: directed corner cases plus random regression, with
// a queue-based scoreboard fed by the driver and drained by a monitor.
module tb_claa_mp_seq;
    localparam int WW = 8;
    localparam int CH = 4;
    localparam int N  = WW * CH;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic [1:0] dbg_state;

    always #5 clk_i = ~clk_i;

    claa_mp_seq_if #(.WORD_WIDTH(WW), .CHUNKS(CH)) bus ();

    claa_mp_seq #(.WORD_WIDTH(WW), .CHUNKS(CH)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // expected entry layout: {r, c, v, z}
    logic [N+2:0] exp_q[$];
    int           acc_q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rdy_mode = 0;  // 0: always ready, 1: random stalls, 2: manual

    always @(posedge clk_i) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: exact unsigned and signed arithmetic on wide integers.
    function automatic logic [N+2:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic sub, input logic c);
        logic [N:0] full;
        logic [N-1:0] r;
        longint sa, sb, sres, smax, smin;
        logic v;
        if (sub) full = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, c};
        else     full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
        r    = full[N-1:0];
        sa   = $signed(a);
        sb   = $signed(b);
        sres = sub ? (sa - sb - longint'(c)) : (sa + sb + longint'(c));
        smax = (longint'(1) <<< (N - 1)) - 1;
        smin = -(longint'(1) <<< (N - 1));
        v    = (sres > smax) || (sres < smin);
        return {r, full[N], v, (r == '0)};
    endfunction

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (rdy_mode == 0)      bus.ready_i = 1'b1;
            else if (rdy_mode == 1) bus.ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: latency on each rising valid_o, result on each handshake.
    logic prev_v = 1'b0;
    always @(negedge clk_i) begin : monitor
        int a0;
        logic [N+2:0] e;
        if (!rst_ni) begin
            prev_v = 1'b0;
        end else begin
            if (bus.valid_o && !prev_v) begin
                if (acc_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL latency: valid_o with no accepted request at cycle %0d", cyc);
                end else begin
                    a0 = acc_q.pop_front();
                    check("latency", 64'(cyc - a0), 64'(CH));
                end
            end
            if (bus.valid_o && bus.ready_i) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL result: unexpected result %0h at cycle %0d", bus.r_o, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("result{r,c,v,z}", 64'({bus.r_o, bus.c_o, bus.v_o, bus.z_o}), 64'(e));
                end
            end
            prev_v = bus.valid_o;
        end
    end

    // Called in the post-edge phase; returns in the post-edge phase after accept.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                         input logic c, input logic [N+2:0] exp);
        int n = 0;
        while (!bus.ready_o && n < 60) begin
            bus.valid_i = 1'($urandom_range(0, 1));
            bus.a_i     = $urandom;
            bus.b_i     = $urandom;
            bus.sub_i   = 1'($urandom_range(0, 1));
            bus.c_i     = 1'($urandom_range(0, 1));
            @(posedge clk_i); #1;
            n++;
        end
        if (!bus.ready_o) begin
            total++; bad++;
            $display("FAIL issue_wait: ready_o stuck at %0b expected 1", bus.ready_o);
            bus.valid_i = 1'b0;
            return;
        end
        bus.valid_i = 1'b1;
        bus.a_i = a; bus.b_i = b; bus.sub_i = sub; bus.c_i = c;
        exp_q.push_back(exp);
        @(posedge clk_i); #1;
        acc_q.push_back(cyc);
        bus.valid_i = 1'($urandom_range(0, 1));
        bus.a_i     = $urandom;
        bus.b_i     = $urandom;
        bus.sub_i   = 1'($urandom_range(0, 1));
        bus.c_i     = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        bus.valid_i = 1'b0;
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [N-1:0] ra, rb;
        logic rs, rc;
        logic [N-1:0] edge_vals[4];
        int n;
        edge_vals[0] = '0; edge_vals[1] = '1;
        edge_vals[2] = {1'b1, {(N-1){1'b0}}}; edge_vals[3] = {1'b0, {(N-1){1'b1}}};
        bus.valid_i = 1'b0; bus.sub_i = 1'b0; bus.c_i = 1'b0;
        bus.a_i = '0; bus.b_i = '0; bus.ready_i = 1'b1;

        #2;
        check("reset_ready_o", 64'(bus.ready_o), 64'd1);
        check("reset_valid_o", 64'(bus.valid_o), 64'd0);
        check("reset_r_o", 64'(bus.r_o), 64'd0);
        check("reset_flags", 64'({bus.c_o, bus.v_o, bus.z_o}), 64'd0);
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {32'h0000_0000, 1'b1, 1'b0, 1'b1});
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {32'h8000_0000, 1'b0, 1'b1, 1'b0});
        issue(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, {32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0});
        issue(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, {32'h0000_0001, 1'b0, 1'b0, 1'b0});
        drain();

        // Back-pressure with ignored requests in RUN and DONE.
        rdy_mode = 2;
        bus.ready_i = 1'b0;
        issue(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, {32'h0000_0000, 1'b1, 1'b1, 1'b1});
        bus.valid_i = 1'b1; bus.a_i = 32'h1234_5678; bus.b_i = 32'h0101_0101;
        @(posedge clk_i); #1;
        bus.valid_i = 1'b0;
        n = 0;
        while (!bus.valid_o && n < 20) begin @(posedge clk_i); #1; n++; end
        check("bp_valid_rise", 64'(bus.valid_o), 64'd1);
        bus.valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("bp_valid_o", 64'(bus.valid_o), 64'd1);
            check("bp_ready_o", 64'(bus.ready_o), 64'd0);
            check("bp_r_o", 64'(bus.r_o), 64'd0);
            check("bp_flags", 64'({bus.c_o, bus.v_o, bus.z_o}), 64'b111);
            @(posedge clk_i); #1;
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        @(posedge clk_i); #1;
        check("release_ready_o", 64'(bus.ready_o), 64'd1);
        check("release_valid_o", 64'(bus.valid_o), 64'd0);
        check("idle_hold_r_o", 64'(bus.r_o), 64'd0);
        check("idle_hold_flags", 64'({bus.c_o, bus.v_o, bus.z_o}), 64'b111);
        rdy_mode = 0;
        drain();

        // Asynchronous reset while chunk 2 is being computed.
        issue(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, model(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0));
        @(posedge clk_i); #2;
        rst_ni = 1'b0;
        bus.valid_i = 1'b0;
        exp_q.delete();
        acc_q.delete();
        #1;
        check("abort_valid_o", 64'(bus.valid_o), 64'd0);
        check("abort_r_o", 64'(bus.r_o), 64'd0);
        check("abort_flags", 64'({bus.c_o, bus.v_o, bus.z_o}), 64'd0);
        check("abort_ready_o", 64'(bus.ready_o), 64'd1);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, {32'h2345_6789, 1'b0, 1'b0, 1'b0});
        drain();

        // Random regression with consumer stalls.
        rdy_mode = 1;
        for (int t = 0; t < 10000; t++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) ra = edge_vals[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0) rb = edge_vals[$urandom_range(0, 3)];
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            issue(ra, rb, rs, rc, model(ra, rb, rs, rc));
        end
        drain();
        rdy_mode = 0;
        check("latency_pending", 64'(acc_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
